esm_issue_retire: RTL

//   Consumer end of the ESM scheduling path: accepts ready buffer indices (with

---
 rtl/esm_issue_retire_if.sv | 36 +++
 rtl/esm_issue_retire.sv | 118 +++++++++++
 2 files changed

// File: rtl/esm_issue_retire_if.sv
// Handshake bundle between the ESM scheduler, the issue/retire block and the
// execution unit. The slave modport is the issue/retire block itself.
interface esm_issue_retire_if #(
    parameter int bs     = 16,
    parameter int regnum = 32
);
    localparam int bs_bits  = $clog2(bs);
    localparam int reg_bits = $clog2(regnum);
    localparam int hc_bits  = $clog2(bs + 1);

    logic                rdy_valid;
    logic [bs_bits-1:0]  rdy_index;
    logic [reg_bits-1:0] rdy_rd;
    logic                rdy_accept;
    logic                issue_valid;
    logic [bs_bits-1:0]  issue_index;
    logic                issue_ready;
    logic                free_valid;
    logic [bs_bits-1:0]  free_index;
    logic                wb_valid;
    logic [reg_bits-1:0] wb_rd;
    logic [hc_bits-1:0]  held_cnt;
    logic                dup_err;

    modport master (
        output rdy_valid, rdy_index, rdy_rd, issue_ready,
        input  rdy_accept, issue_valid, issue_index, free_valid, free_index,
               wb_valid, wb_rd, held_cnt, dup_err
    );

    modport slave (
        input  rdy_valid, rdy_index, rdy_rd, issue_ready,
        output rdy_accept, issue_valid, issue_index, free_valid, free_index,
               wb_valid, wb_rd, held_cnt, dup_err
    );
endinterface

// File: rtl/esm_issue_retire.sv
// In-order issue queue feeding a fixed-latency execution pipe; retiring entries
// free their buffer slot and wake their destination register.
module esm_issue_retire #(
    parameter int bs       = 16,
    parameter int regnum   = 32,
    parameter int Q_DEPTH  = 4,
    parameter int EXEC_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    esm_issue_retire_if.slave  bus
);
    localparam int bs_bits  = $clog2(bs);
    localparam int reg_bits = $clog2(regnum);
    localparam int hc_bits  = $clog2(bs + 1);
    localparam int PTR_W    = $clog2(Q_DEPTH);
    localparam int CNT_W    = $clog2(Q_DEPTH + 1);
    localparam logic [hc_bits-1:0] HC_MAX = hc_bits'(Q_DEPTH + EXEC_LAT);

    // Held-count update; clamps at both ends so it can never wrap.
    function automatic logic [hc_bits-1:0] cnt_step(
        input logic [hc_bits-1:0] c,
        input logic               inc,
        input logic               dec
    );
        if (inc && !dec && c != HC_MAX)
            return c + 1'b1;
        else if (dec && !inc && c != '0)
            return c - 1'b1;
        else
            return c;
    endfunction

    logic [bs_bits-1:0]  q_idx [Q_DEPTH];
    logic [reg_bits-1:0] q_rd  [Q_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    q_cnt;

    logic                vld_p [1:EXEC_LAT];
    logic [bs_bits-1:0]  idx_p [1:EXEC_LAT];
    logic [reg_bits-1:0] rd_p  [1:EXEC_LAT];

    logic [bs-1:0]       held;
    logic [bs-1:0]       held_after;
    logic [bs-1:0]       push_mask;
    logic [hc_bits-1:0]  held_cnt_r;
    logic                dup_err_r;

    logic q_empty, q_full, push_hs, is_dup, push, pop, retire;

    always_comb begin
        q_empty = (q_cnt == '0);
        q_full  = (q_cnt == CNT_W'(Q_DEPTH));
        push_hs = bus.rdy_valid && !q_full;
        retire  = vld_p[EXEC_LAT];
        // A slot retiring this cycle may be re-pushed in the same cycle.
        held_after = held;
        if (retire)
            held_after[idx_p[EXEC_LAT]] = 1'b0;
        is_dup    = held_after[bus.rdy_index];
        push      = push_hs && !is_dup;
        pop       = !q_empty && bus.issue_ready;
        push_mask = push ? (bs'(1) << bus.rdy_index) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_cnt      <= '0;
            held       <= '0;
            held_cnt_r <= '0;
            dup_err_r  <= 1'b0;
            for (int k = 1; k <= EXEC_LAT; k++)
                vld_p[k] <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                q_cnt <= q_cnt + 1'b1;
            else if (pop && !push)
                q_cnt <= q_cnt - 1'b1;
            held       <= held_after | push_mask;
            held_cnt_r <= cnt_step(held_cnt_r, push, retire);
            dup_err_r  <= dup_err_r | (push_hs && is_dup);
            vld_p[1] <= pop;
            for (int k = 2; k <= EXEC_LAT; k++)
                vld_p[k] <= vld_p[k-1];
        end
    end

    // Data path: queue storage and pipe payload, qualified by the valids above
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr] <= bus.rdy_index;
            q_rd[wr_ptr]  <= bus.rdy_rd;
        end
        idx_p[1] <= q_idx[rd_ptr];
        rd_p[1]  <= q_rd[rd_ptr];
        for (int k = 2; k <= EXEC_LAT; k++) begin
            idx_p[k] <= idx_p[k-1];
            rd_p[k]  <= rd_p[k-1];
        end
    end

    // Retire stage outputs
    assign bus.rdy_accept  = !q_full;
    assign bus.issue_valid = !q_empty;
    assign bus.issue_index = q_empty ? '0 : q_idx[rd_ptr];
    assign bus.free_valid  = vld_p[EXEC_LAT];
    assign bus.free_index  = vld_p[EXEC_LAT] ? idx_p[EXEC_LAT] : '0;
    assign bus.wb_valid    = vld_p[EXEC_LAT] && (rd_p[EXEC_LAT] != '0);
    assign bus.wb_rd       = bus.wb_valid ? rd_p[EXEC_LAT] : '0;
    assign bus.held_cnt    = held_cnt_r;
    assign bus.dup_err     = dup_err_r;
endmodule
